// File: rtl/simd_mac_cfu_pkg.sv
// simd_mac_cfu_pkg: opcodes, FSM states, accumulator width and saturating add for simd_mac_cfu
package simd_mac_cfu_pkg;
   localparam int ACC_W = 32;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_CLEAR, OP_READ, OP_SETOFF, OP_WRITE
   } op_e;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
   // Signed 32-bit add clamped to 0x7FFFFFFF / 0x80000000 on overflow
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      return (s[ACC_W] == s[ACC_W-1]) ? s[ACC_W-1:0] : (s[ACC_W] ? 32'h8000_0000 : 32'h7FFF_FFFF);
   endfunction
endpackage

// File: rtl/simd_mac_cfu_if.sv
// simd_mac_cfu_if: CPU custom-instruction command/response bus
//   master (CPU): drives cmd_valid, cmd_payload_*, rsp_ready
//   slave (CFU):  drives cmd_ready, rsp_valid, rsp_payload_outputs_0
interface simd_mac_cfu_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   modport master(output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
                  input cmd_ready, rsp_valid, rsp_payload_outputs_0);
   modport slave(input cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
                 output cmd_ready, rsp_valid, rsp_payload_outputs_0);
endinterface

// File: rtl/simd_mac_cfu_lanes.sv
// simd_mac_lanes: packed-lane offset multiply + adder tree and 32-bit multiply, behind a MUL_STAGES-deep pipeline
//   in:  clk, reset, in_valid/in_mac/in_sel tags, a, b operands, offset (signed LANE_W+1 bits)
//   out: out_valid/out_mac/out_sel tags, out_sum (lane dot product, 32-bit), out_mul (low 32 bits of a*b)
module simd_mac_lanes #(
   parameter int LANE_W = 8,
   parameter int SEL_W = 2,
   parameter int MUL_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_mac,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   input  logic signed [LANE_W:0] offset,
   output logic              out_valid,
   output logic              out_mac,
   output logic [SEL_W-1:0]  out_sel,
   output logic [31:0]       out_sum,
   output logic [31:0]       out_mul
);
   localparam int LANES = 32 / LANE_W;
   localparam int PW = 2 * LANE_W + 4;
   localparam int SW = PW + 2;
   typedef struct packed {
      logic             valid;
      logic             mac;
      logic [SEL_W-1:0] sel;
      logic [31:0]      sum;
      logic [31:0]      mul;
   } pipe_t;
   logic signed [LANE_W+1:0] ao;
   logic signed [PW-1:0] prod;
   logic signed [SW-1:0] dot;
   pipe_t st_in, st_out;
   always_comb begin
      dot = '0;
      ao = '0;
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         ao = (LANE_W+2)'($signed(a[i*LANE_W +: LANE_W])) + (LANE_W+2)'(offset);
         prod = PW'(ao) * PW'($signed(b[i*LANE_W +: LANE_W]));
         dot = dot + SW'(prod);
      end
   end
   assign st_in = '{valid: in_valid, mac: in_mac, sel: in_sel, sum: 32'(dot), mul: a * b};
   if (MUL_STAGES == 0) begin : g_comb
      assign st_out = st_in;
   end else begin : g_pipe
      pipe_t q [MUL_STAGES];
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int s = 0; s < MUL_STAGES; s++) q[s] <= '0;
         end else begin
            q[0] <= st_in;
            for (int s = 1; s < MUL_STAGES; s++) q[s] <= q[s-1];
         end
      end
      assign st_out = q[MUL_STAGES-1];
   end
   assign out_valid = st_out.valid;
   assign out_mac = st_out.mac;
   assign out_sel = st_out.sel;
   assign out_sum = st_out.sum;
   assign out_mul = st_out.mul;
endmodule

// File: rtl/simd_mac_cfu.sv
// simd_mac_cfu: quantised-conv CFU with scalar ADD/SUB/MUL and SIMD MAC into NUM_ACC accumulators
//   clk, reset (sync, active-high); bus: simd_mac_cfu_if.slave command/response port
//   CFU_MAC_SAT_EN: when defined, MAC accumulation saturates to signed 32-bit instead of wrapping
module simd_mac_cfu
   import simd_mac_cfu_pkg::*;
#(
   parameter int LANE_W = 8,
   parameter int NUM_ACC = 4,
   parameter int MUL_STAGES = 2
) (
   input logic clk,
   input logic reset,
   simd_mac_cfu_if.slave bus
);
   localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
   state_e state, state_n;
   logic [2:0] cnt;
   logic [ACC_W-1:0] acc [NUM_ACC];
   logic signed [LANE_W:0] offset;
   logic [ACC_W-1:0] rsp_data, rsp_d, mac_new, a, b, psum, pmul;
   logic [SEL_W-1:0] sel, psel;
   logic accept, mul_path, pvalid, pmac;
   op_e op;
   assign a = bus.cmd_payload_inputs_0;
   assign b = bus.cmd_payload_inputs_1;
   assign op = op_e'(bus.cmd_payload_function_id[2:0]);
   // Out-of-range selects wrap because NUM_ACC is a power of two
   assign sel = bus.cmd_payload_function_id[3 +: SEL_W] & SEL_W'(NUM_ACC - 1);
   assign mul_path = (op == OP_MUL) || (op == OP_MAC);
   assign accept = bus.cmd_valid && (state == IDLE);
   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_payload_outputs_0 = rsp_data;
   simd_mac_lanes #(.LANE_W(LANE_W), .SEL_W(SEL_W), .MUL_STAGES(MUL_STAGES)) u_lanes (
      .clk(clk), .reset(reset),
      .in_valid(accept && mul_path), .in_mac(op == OP_MAC), .in_sel(sel),
      .a(a), .b(b), .offset(offset),
      .out_valid(pvalid), .out_mac(pmac), .out_sel(psel), .out_sum(psum), .out_mul(pmul)
   );
`ifdef CFU_MAC_SAT_EN
   assign mac_new = sat_add(acc[psel], psum);
`else
   assign mac_new = acc[psel] + psum;
`endif
   assign rsp_d = (op == OP_ADD) ? a + b :
                  (op == OP_SUB) ? a - b :
                  (op == OP_CLEAR || op == OP_READ) ? acc[sel] :
                  (op == OP_SETOFF) ? '0 : a;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept) state_n = (mul_path && MUL_STAGES > 0) ? BUSY : RESP;
         BUSY: if (cnt == 3'(MUL_STAGES - 1)) state_n = RESP;
         RESP: if (bus.rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // Pipeline output lines up with the edge that enters RESP, so MUL/MAC results land here
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         offset <= '0;
         rsp_data <= '0;
         for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      end else begin
         state <= state_n;
         cnt <= (state == BUSY) ? cnt + 3'd1 : 3'd0;
         if (pvalid) begin
            rsp_data <= pmac ? mac_new : pmul;
            if (pmac) acc[psel] <= mac_new;
         end
         if (accept && !mul_path) begin
            rsp_data <= rsp_d;
            if (op == OP_CLEAR) acc[sel] <= '0;
            if (op == OP_WRITE) acc[sel] <= a;
            if (op == OP_SETOFF) offset <= a[LANE_W:0];
         end
      end
   end
endmodule

// File: tb/tb_simd_mac_cfu.sv
// tb_simd_mac_cfu: scoreboard bench for simd_mac_cfu (LANE_W=8, NUM_ACC=4, MUL_STAGES=2)
module tb_simd_mac_cfu;
   import simd_mac_cfu_pkg::*;
   localparam int MS = 2;
`ifdef CFU_MAC_SAT_EN
   localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] SAT_EXP = 32'h8000_FBF4;
`endif
   logic clk = 0;
   logic reset = 1;
   always #5 clk = ~clk;
   simd_mac_cfu_if bus();
   simd_mac_cfu #(.LANE_W(8), .NUM_ACC(4), .MUL_STAGES(MS)) dut (.clk(clk), .reset(reset), .bus(bus));
   int vectors = 0;
   int miscompares = 0;
   int lat;
   logic [31:0] sb[$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic issue(input op_e op, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1;
      bus.cmd_payload_function_id = {f7, op};
      bus.cmd_payload_inputs_0 = a;
      bus.cmd_payload_inputs_1 = b;
      @(negedge clk);
      bus.cmd_valid = 0;
   endtask
   task automatic wait_rsp(input string tag, output int l);
      logic [31:0] exp;
      l = 1;
      while (!bus.rsp_valid && l < 50) begin
         @(negedge clk);
         l++;
      end
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      check(tag, bus.rsp_payload_outputs_0, exp);
   endtask
   task automatic run(input string tag, input op_e op, input logic [6:0] f7, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      sb.push_back(exp);
      issue(op, f7, a, b);
      wait_rsp(tag, lat);
      @(negedge clk);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
   initial begin
      bus.cmd_valid = 0;
      bus.cmd_payload_function_id = '0;
      bus.cmd_payload_inputs_0 = '0;
      bus.cmd_payload_inputs_1 = '0;
      bus.rsp_ready = 1;
      repeat (3) @(negedge clk);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      reset = 0;
      @(negedge clk);
      check("reset_rsp_data", bus.rsp_payload_outputs_0, 32'd0);
      check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      run("write0", OP_WRITE, 7'd0, 32'd0, 32'd0, 32'd0);
      run("setoff0", OP_SETOFF, 7'd0, 32'd0, 32'd0, 32'd0);
      run("mac0_off0", OP_MAC, 7'd0, 32'h0102_0304, 32'h0506_0708, 32'h0000_0046);
      check("mac_latency", 32'(lat), 32'(MS + 1));
      run("setoff1", OP_SETOFF, 7'd0, 32'd1, 32'd0, 32'd0);
      run("mac0_off1", OP_MAC, 7'd0, 32'h0102_0304, 32'h0506_0708, 32'h0000_00A6);
      run("read1", OP_READ, 7'd1, 32'd0, 32'd0, 32'd0);
      run("read_wrap4", OP_READ, 7'd4, 32'd0, 32'd0, 32'h0000_00A6);
      run("setoff0b", OP_SETOFF, 7'd0, 32'd0, 32'd0, 32'd0);
      run("mac2_neg", OP_MAC, 7'd2, 32'h0000_00FF, 32'h0000_0002, 32'hFFFF_FFFE);
      run("clear2", OP_CLEAR, 7'd2, 32'd0, 32'd0, 32'hFFFF_FFFE);
      run("read2", OP_READ, 7'd2, 32'd0, 32'd0, 32'd0);
      run("setoff_m1", OP_SETOFF, 7'd0, 32'h0000_01FF, 32'd0, 32'd0);
      run("mac1_offm1", OP_MAC, 7'd1, 32'h0202_0202, 32'h0303_0303, 32'h0000_000C);
      run("setoff0c", OP_SETOFF, 7'd0, 32'd0, 32'd0, 32'd0);
      run("write3", OP_WRITE, 7'd3, 32'h7FFF_FFF0, 32'd0, 32'h7FFF_FFF0);
      run("mac3_ovf", OP_MAC, 7'd3, 32'h7F7F_7F7F, 32'h7F7F_7F7F, SAT_EXP);
      run("add", OP_ADD, 7'd0, 32'd5, 32'd7, 32'd12);
      check("add_latency", 32'(lat), 32'd1);
      run("sub", OP_SUB, 7'd0, 32'd3, 32'd5, 32'hFFFF_FFFE);
      run("mul_ones", OP_MUL, 7'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      check("mul_latency", 32'(lat), 32'(MS + 1));
      run("mul_wrap", OP_MUL, 7'd0, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
      bus.rsp_ready = 0;
      sb.push_back(32'd1);
      issue(OP_ADD, 7'd0, 32'hFFFF_FFFF, 32'd2);
      wait_rsp("add_hold", lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_data", bus.rsp_payload_outputs_0, 32'd1);
         check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         if (i == 1) begin
            bus.cmd_valid = 1;
            bus.cmd_payload_function_id = {7'd0, OP_WRITE};
            bus.cmd_payload_inputs_0 = 32'h1234_5678;
         end
         if (i == 2) bus.cmd_valid = 0;
      end
      bus.rsp_ready = 1;
      @(negedge clk);
      check("hold_released", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("ignored_cmd_no_rsp", 32'(bus.rsp_valid), 32'd0);
      run("read0_after_ignored", OP_READ, 7'd0, 32'd0, 32'd0, 32'h0000_00A6);
      issue(OP_MAC, 7'd0, 32'h0102_0304, 32'h0506_0708);
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 6; i++) begin
         check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
         @(negedge clk);
      end
      check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      run("read0_after_reset", OP_READ, 7'd0, 32'd0, 32'd0, 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/simd_mac_cfu.md
Name: simd_mac_cfu

Overview:
Parametrised CFU for quantised convolution kernels, attached to the CPU custom-instruction port.
- Executes scalar ADD/SUB/MUL.
- Executes packed-lane SIMD multiply-accumulate with a per-operand input offset.
- Holds NUM_ACC independent accumulators, so several output channels accumulate in parallel.
- Multiply path is pipelined to MUL_STAGES, so MUL/MAC are multi-cycle behind a valid/ready handshake.

Parameters:
LANE_W, 8, signed lane width; legal 8 or 16; LANES = 32/LANE_W (localparam).
NUM_ACC, 4, number of 32-bit accumulators; power of two, 1..8.
MUL_STAGES, 2, extra register stages on the MUL/MAC path; 0..4.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_payload_function_id  in  10  [2:0] funct3 opcode, [9:3] funct7 (accumulator select in [log2(NUM_ACC)+2:3])
cmd_payload_inputs_0  in  32  operand A
cmd_payload_inputs_1  in  32  operand B
rsp_valid  out  1  result valid
rsp_ready  in  1  CPU accepts result
rsp_payload_outputs_0  out  32  result

Behaviour:
- Clocking and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: rsp_valid=0, rsp_payload_outputs_0=0, all accumulators=0, offset=0, FSM=IDLE.
- Reset mid-operation aborts any in-flight op; no response is produced.
- Handshake: command accepted on a clk edge with cmd_valid && cmd_ready.
- FSM states:
  - IDLE: on accept, go to BUSY if opcode is MUL/MAC and MUL_STAGES>0, else RESP.
  - BUSY: counter counts MUL_STAGES cycles, then RESP.
  - RESP: rsp_valid=1; hold until rsp_ready=1, then IDLE.
- Latency: rsp_valid rises 1 cycle after accept for single-cycle ops, and 1+MUL_STAGES cycles after accept for MUL/MAC.
- cmd_valid while not IDLE is ignored (cmd_ready=0).
- rsp_payload_outputs_0 is stable for the whole RESP period.
- Next command can be accepted the cycle after the rsp handshake (no same-cycle overlap).
- Opcodes (funct3); sel = accumulator index:
  - 0 ADD: A+B, mod 2^32.
  - 1 SUB: A-B, mod 2^32.
  - 2 MUL: low 32 bits of A*B, unsigned.
  - 3 MAC: acc[sel] += sum over lanes of (sext(A_lane)+offset) * sext(B_lane). Lane sums use full-precision signed arithmetic; the final add is 32-bit. Returns the new acc[sel].
  - 4 CLEAR: returns old acc[sel], then sets acc[sel]=0.
  - 5 READ: returns acc[sel].
  - 6 SETOFF: offset = signed A[LANE_W:0] (LANE_W+1 bits); returns 0.
  - 7 WRITE: acc[sel]=A; returns A.
- A sel value ≥ NUM_ACC wraps modulo NUM_ACC (upper funct7 bits ignored).
- The offset captured at accept is used for that MAC; a SETOFF cannot overlap a MAC.
- The accumulator is updated on the same edge that RESP is entered.

Optional Feature:
Macro CFU_MAC_SAT_EN.
- Defined: MAC accumulation saturates to signed 32-bit, 0x7FFFFFFF / 0x80000000.
- Undefined: MAC accumulation wraps mod 2^32.
- ADD/SUB/MUL always wrap, in both configurations.

Decomposition:
Package simd_mac_cfu_pkg holds:
- opcode enum: OP_ADD..OP_WRITE
- FSM state enum: IDLE/BUSY/RESP
- ACC_W=32
- saturating-add function

One sub-module, simd_mac_lanes: combinational lane multiply, offset add and adder tree, followed by a MUL_STAGES-deep pipeline carrying a valid bit and sel.

Test Plan:
- Reset, WRITE acc0=0, SETOFF 0, MAC sel0 A=0x01020304 B=0x05060708 → rsp 0x00000046, rsp_valid exactly 3 cycles after accept (MUL_STAGES=2).
- SETOFF A=1, then MAC sel0 with same operands → rsp 0x000000A6. READ sel1 → 0 (accumulators independent).
- MAC sel2 A=0x000000FF B=0x00000002, offset 0 → 0xFFFFFFFE. CLEAR sel2 → 0xFFFFFFFE, then READ sel2 → 0.
- WRITE acc3=0x7FFFFFF0, MAC sel3 A=B=0x7F7F7F7F:
  - with CFU_MAC_SAT_EN → 0x7FFFFFFF
  - without → 0x8000FBF4
- Hold rsp_ready=0 for 5 cycles after ADD 0xFFFFFFFF+2:
  - rsp 0x00000001 stable throughout
  - cmd_ready=0 throughout
  - a cmd_valid pulse during the hold is ignored
- Assert reset in the BUSY cycle of a MAC → no response; after release READ sel0 → 0 and cmd_ready=1.
